// File: rtl/instr_switch_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_switch_decoder                                             |
// | Brief   : 2-stage valid/ready decoder from switch-encoder instruction words |
// |           back to the 15-bit switch code, with decode/error statistics.    |
// |           Optional build macro SWDEC_DROP_ERR_EN suppresses error words.   |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_switch_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_code,
  output logic        out_nop,
  output logic        out_err,
  input  logic        clr,
  output logic [15:0] dec_count,
  output logic [7:0]  err_count,
  output logic        err_sticky
);

`ifdef SWDEC_DROP_ERR_EN
  localparam logic DROP_ERR = 1'b1;
`else
  localparam logic DROP_ERR = 1'b0;
`endif

  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  OP_ADDI    = 6'b001000;
  localparam logic [5:0]  OP_ORI     = 6'b001001;
  localparam logic [5:0]  OP_ANDI    = 6'b001100;
  localparam logic [5:0]  OP_XORI    = 6'b001110;
  localparam logic [5:0]  OP_LUI     = 6'b001111;
  localparam logic [15:0] LOW_ADD    = 16'h7820;
  localparam logic [15:0] LOW_NOR    = 16'h7827;
  localparam logic [4:0]  REG_FIXED  = 5'd15;

  typedef struct packed {
    logic [14:0] code;
    logic        nop;
    logic        err;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        i_ok;
    logic        r_ok;
    dec_t        r;
    op    = w[31:26];
    rs    = w[25:21];
    rt    = w[20:16];
    rd    = w[15:11];
    shamt = w[10:6];
    funct = w[5:0];
    imm   = w[15:0];
    r.code = 15'd0;
    r.nop  = 1'b0;
    r.err  = 1'b0;
    // Immediate forms always target $15 with a byte-sized immediate.
    i_ok = (rt == REG_FIXED) && !rs[4] && (imm[15:8] == 8'd0);
    r_ok = (op == OP_SPECIAL) && !rs[4] && !rt[4];
    if (w == 32'd0) begin
      r.nop = 1'b1;
    end else if (op == OP_ADDI && i_ok) begin
      r.code = {3'b000, rs[3:0], imm[7:0]};
    end else if (r_ok && imm == LOW_ADD) begin
      r.code = {3'b001, rs[3:0], rt[3:0], 4'b0000};
    end else if (op == OP_SPECIAL && rs == 5'd0 && rd == REG_FIXED &&
                 funct == 6'd0 && !rt[4]) begin
      r.code = {3'b010, rt[3:0], shamt, 3'b000};
    end else if (op == OP_ANDI && i_ok) begin
      r.code = {3'b011, rs[3:0], imm[7:0]};
    end else if (op == OP_ORI && i_ok) begin
      r.code = {3'b100, rs[3:0], imm[7:0]};
    end else if (r_ok && imm == LOW_NOR) begin
      r.code = {3'b101, rs[3:0], rt[3:0], 4'b0000};
    end else if (op == OP_XORI && i_ok) begin
      r.code = {3'b110, rs[3:0], imm[7:0]};
    end else if (op == OP_LUI && i_ok && rs == 5'd0) begin
      r.code = {3'b111, 4'b0000, imm[7:0]};
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic        out_valid_q, out_valid_d;
  logic [14:0] out_code_q, out_code_d;
  logic        out_nop_q, out_nop_d;
  logic        out_err_q, out_err_d;
  logic [15:0] dec_count_q, dec_count_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        err_sticky_q, err_sticky_d;

  logic        adv;
  logic        err_load;
  dec_t        s1_dec;

  always_comb begin
    adv          = !out_valid_q || out_ready;
    s1_dec       = decode(s1_instr_q);
    err_load     = adv && s1_valid_q && s1_dec.err;

    s1_valid_d   = s1_valid_q;
    s1_instr_d   = s1_instr_q;
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    out_nop_d    = out_nop_q;
    out_err_d    = out_err_q;
    dec_count_d  = dec_count_q;
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;

    // Both stages move together, so a stall never drops or repeats a word.
    if (adv) begin
      s1_valid_d  = in_valid;
      if (in_valid) begin
        s1_instr_d = in_instr;
      end
      out_valid_d = s1_valid_q && !(DROP_ERR && s1_dec.err);
      if (s1_valid_q) begin
        out_code_d = s1_dec.code;
        out_nop_d  = s1_dec.nop;
        out_err_d  = s1_dec.err;
      end
    end

    if (clr) begin
      dec_count_d  = 16'd0;
      err_count_d  = 8'd0;
      err_sticky_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        dec_count_d = dec_count_q + 16'd1;
      end
      if (err_load) begin
        err_sticky_d = 1'b1;
        if (err_count_q != 8'hFF) begin
          err_count_d = err_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_instr_q   <= 32'd0;
      out_valid_q  <= 1'b0;
      out_code_q   <= 15'd0;
      out_nop_q    <= 1'b0;
      out_err_q    <= 1'b0;
      dec_count_q  <= 16'd0;
      err_count_q  <= 8'd0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_instr_q   <= s1_instr_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_nop_q    <= out_nop_d;
      out_err_q    <= out_err_d;
      dec_count_q  <= dec_count_d;
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Held high through reset so the producer never sees a spurious stall.
  assign in_ready   = adv || rst;
  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_nop    = out_nop_q;
  assign out_err    = out_err_q && !DROP_ERR;
  assign dec_count  = dec_count_q;
  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_switch_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_switch_decoder                                          |
// | Brief   : Table-driven, scoreboard-checked bench for instr_switch_decoder.  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_switch_decoder;

`ifdef SWDEC_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic        out_nop;
  logic        out_err;
  logic        clr;
  logic [15:0] dec_count;
  logic [7:0]  err_count;
  logic        err_sticky;

  instr_switch_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_nop    (out_nop),
    .out_err    (out_err),
    .clr        (clr),
    .dec_count  (dec_count),
    .err_count  (err_count),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [14:0] code;
    logic        nop;
    logic        err;
  } vec_t;

  typedef struct {
    logic [14:0] code;
    logic        nop;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_dec  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive a word until accepted; expected result is queued on acceptance.
  task automatic send(input vec_t v);
    bit   acc;
    int   k;
    exp_t e;
    acc = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_instr = v.instr;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      k++;
    end
    #1;
    in_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 32'(acc), 32'd1);
    else if (!(DROP && v.err)) begin
      e.code = v.code;
      e.nop  = v.nop;
      e.err  = v.err;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard compare on every handshake, plus hold stability.
  initial begin
    bit          stall_prev;
    logic [14:0] prev_code;
    exp_t        e;
    stall_prev = 1'b0;
    prev_code  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_out_valid", 32'(out_valid), 32'd1);
          chk("hold_out_code", 32'(out_code), 32'(prev_code));
        end
        if (out_valid && out_ready) begin
          chk("sb_has_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_code", 32'(out_code), 32'(e.code));
            chk("out_nop", 32'(out_nop), 32'(e.nop));
            chk("out_err", 32'(out_err), 32'(e.err));
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_code  = out_code;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t single[4];
  vec_t tbl[14];
  vec_t bad;

  initial begin
    int n_good;
    int n_bad;
    bit saw_full;
    int stale;

    single[0] = '{32'h212F0034, 15'h0934, 1'b0, 1'b0};
    single[1] = '{32'h00657827, 15'h5350, 1'b0, 1'b0};
    single[2] = '{32'h00077A80, 15'h2750, 1'b0, 1'b0};
    single[3] = '{32'h3C0F00AB, 15'h70AB, 1'b0, 1'b0};

    tbl[0]  = '{32'h00467820, 15'h1260, 1'b0, 1'b0};
    tbl[1]  = '{32'h30AF005A, 15'h355A, 1'b0, 1'b0};
    tbl[2]  = '{32'h25EF00FF, 15'h4FFF, 1'b0, 1'b0};
    tbl[3]  = '{32'h380F0001, 15'h6001, 1'b0, 1'b0};
    tbl[4]  = '{32'h00000000, 15'h0000, 1'b1, 1'b0};
    tbl[5]  = '{32'h21230034, 15'h0000, 1'b0, 1'b1};
    tbl[6]  = '{32'h3C2F0001, 15'h0000, 1'b0, 1'b1};
    tbl[7]  = '{32'h212F0134, 15'h0000, 1'b0, 1'b1};
    tbl[8]  = '{32'h02067820, 15'h0000, 1'b0, 1'b1};
    tbl[9]  = '{32'h00077A81, 15'h0000, 1'b0, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, 15'h0000, 1'b0, 1'b1};
    tbl[11] = '{32'h000F7FC0, 15'h2FF8, 1'b0, 1'b0};
    tbl[12] = '{32'h01EF7827, 15'h5FF0, 1'b0, 1'b0};
    tbl[13] = '{32'h3C0F0000, 15'h7000, 1'b0, 1'b0};
    bad     = '{32'h21230034, 15'h0000, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_code", 32'(out_code), 32'd0);
    chk("reset_out_nop", 32'(out_nop), 32'd0);
    chk("reset_out_err", 32'(out_err), 32'd0);
    chk("reset_dec_count", 32'(dec_count), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_err_sticky", 32'(err_sticky), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single words with latency check on the first.
    send(single[0]);
    @(negedge clk);
    chk("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_two_edges", 32'(out_valid), 32'd1);
    drain();
    for (int i = 1; i < 4; i++) begin
      send(single[i]);
      drain();
    end
    exp_dec = 4;
    chk("singles_dec_count", 32'(dec_count), 32'(exp_dec));
    chk("singles_err_count", 32'(err_count), 32'd0);
    chk("singles_err_sticky", 32'(err_sticky), 32'd0);

    // Table streamed back-to-back.
    n_good = 0; n_bad = 0;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i]);
      if (tbl[i].err) n_bad++; else n_good++;
    end
    drain();
    exp_dec += n_good + (DROP ? 0 : n_bad);
    chk("table_dec_count", 32'(dec_count), 32'(exp_dec));
    chk("table_err_count", 32'(err_count), 32'(n_bad));
    chk("table_err_sticky", 32'(err_sticky), 32'd1);

    // Backpressure: first output stalls for three cycles.
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(single[i]);
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 50) begin
          @(posedge clk); #1; k++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_full = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    exp_dec += 4;
    chk("bp_in_ready_low_when_full", 32'(saw_full), 32'd1);
    chk("bp_dec_count", 32'(dec_count), 32'(exp_dec));

    // Error counter saturation, then clr colliding with an error load.
    for (int i = 0; i < 300; i++) send(bad);
    drain();
    chk("sat_err_count", 32'(err_count), 32'hFF);
    chk("sat_err_sticky", 32'(err_sticky), 32'd1);
    send(bad);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_err_count", 32'(err_count), 32'd0);
    chk("clr_err_sticky", 32'(err_sticky), 32'd0);
    chk("clr_dec_count", 32'(dec_count), 32'd0);
    drain();
    chk("post_clr_dec_count", 32'(dec_count), DROP ? 32'd0 : 32'd1);
    chk("post_clr_err_count", 32'(err_count), 32'd0);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(single[0]);
    send(single[1]);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_dec_count", 32'(dec_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midrst_no_stale_output", 32'(stale), 32'd0);
    chk("midrst_final_dec_count", 32'(dec_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
